// File: rtl/rshift_div.sv
// rshift_div -- sequential restoring divider, 12-bit dividend by 6-bit divisor.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous reset, active low (0 = held in reset)
//   load       start request, accepted only in IDLE or DONE
//   dividend   12-bit unsigned dividend
//   divisor    6-bit unsigned divisor
//   quotient   6-bit registered quotient, valid while done=1, else 0
//   remainder  6-bit registered remainder, valid while done=1, else 0
//   busy       high while the divider iterates (RUN)
//   done       high while a result is held (DONE)
//   err        (only with RSHIFT_DIV_ERR_EN) divide-by-zero or quotient overflow
//
// Optional feature: define RSHIFT_DIV_ERR_EN to screen operands at load time.
// Bad operands skip the iteration and report quotient 6'h3F, remainder 0, err=1.
// Without it every operand pair takes the full six-cycle iteration.

module rshift_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] dividend,
  input  logic [5:0]  divisor,
  output logic [5:0]  quotient,
  output logic [5:0]  remainder,
  output logic        busy,
  output logic        done
`ifdef RSHIFT_DIV_ERR_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [12:0] p;
  logic [12:0] pShifted;
  logic [12:0] pStep;
  logic [2:0]  cnt;
  logic [5:0]  divReg;
  logic        accept;
  logic        badOperands;
  logic        lastStep;

  // A load is only honoured outside RUN, so an iteration can never be disturbed.
  assign accept   = load && (state != RUN);
  assign lastStep = (cnt == 3'd5);

  // Operand screening: the quotient only fits in 6 bits when the dividend's
  // upper half is strictly below the divisor (this also rejects divisor 0).
`ifdef RSHIFT_DIV_ERR_EN
  assign badOperands = (divisor == 6'd0) || (dividend[11:6] >= divisor);
`else
  assign badOperands = 1'b0;
`endif

  // One restoring step: shift left, and if the top seven bits cover the
  // divisor, subtract it and shift a 1 into the quotient end of P.
  assign pShifted = {p[11:0], 1'b0};

  always_comb begin
    pStep = pShifted;
    if (pShifted[12:6] >= {1'b0, divReg}) begin
      pStep[12:6] = pShifted[12:6] - {1'b0, divReg};
      pStep[0]    = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and status decoding. DONE with a load behaves like IDLE with
  // a load; screened-out operands jump straight to DONE.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) stateNext = badOperands ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) stateNext = badOperands ? DONE : RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: capture operands on an accepted load, iterate in RUN, and latch
  // the result registers on the final step so they are zero outside DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p         <= 13'd0;
      cnt       <= 3'd0;
      divReg    <= 6'd0;
      quotient  <= 6'd0;
      remainder <= 6'd0;
`ifdef RSHIFT_DIV_ERR_EN
      err       <= 1'b0;
`endif
    end else if (accept) begin
      p         <= {1'b0, dividend};
      divReg    <= divisor;
      cnt       <= 3'd0;
      quotient  <= badOperands ? 6'h3F : 6'd0;
      remainder <= 6'd0;
`ifdef RSHIFT_DIV_ERR_EN
      err       <= badOperands;
`endif
    end else if (state == RUN) begin
      p   <= pStep;
      cnt <= cnt + 3'd1;
      if (lastStep) begin
        quotient  <= pStep[5:0];
        remainder <= pStep[11:6];
      end
    end
  end

endmodule

// File: tb/tb_rshift_div.sv
// tb_rshift_div -- directed testbench for rshift_div.
// Outputs are sampled on the falling clock edge; inputs change there too.
// Build with RSHIFT_DIV_ERR_EN defined to exercise the err port.

module tb_rshift_div;

  logic        clk;
  logic        reset;
  logic        load;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic [5:0]  quotient;
  logic [5:0]  remainder;
  logic        busy;
  logic        done;
`ifdef RSHIFT_DIV_ERR_EN
  logic        err;
`endif

  int checkCount = 0;
  int passCount  = 0;

  rshift_div dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef RSHIFT_DIV_ERR_EN
    ,
    .err       (err)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, actual, actual, expected, expected);
    end
  endtask

  // Presents operands with a one-cycle load pulse. Returns on the falling
  // edge right after the accepting rising edge.
  task automatic applyStimulus(input logic [11:0] dvd, input logic [5:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Full six-cycle division from IDLE or DONE with hand-computed results.
  task automatic runDivision(input string tag, input logic [11:0] dvd,
                             input logic [5:0] dvs, input logic [5:0] expQ,
                             input logic [5:0] expR);
    applyStimulus(dvd, dvs);
    checkOutput({tag, " busy c1"}, busy, 1);
    checkOutput({tag, " done c1"}, done, 0);
    checkOutput({tag, " quot in run"}, quotient, 0);
`ifdef RSHIFT_DIV_ERR_EN
    checkOutput({tag, " err cleared"}, err, 0);
`endif
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s busy c%0d", tag, i), busy, 1);
    end
    @(negedge clk);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " busy off"}, busy, 0);
    checkOutput({tag, " quotient"}, quotient, expQ);
    checkOutput({tag, " remainder"}, remainder, expR);
  endtask

  initial begin
    reset    = 1'b0;
    load     = 1'b1;
    dividend = 12'd30;
    divisor  = 6'd5;

    // Load must be ignored while reset is held.
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
`ifdef RSHIFT_DIV_ERR_EN
    checkOutput("reset err", err, 0);
`endif
    load  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset busy", busy, 0);

    // 30 / 5 = 6 r 0, then DONE must hold without a load.
    runDivision("30/5", 12'd30, 6'd5, 6'd6, 6'd0);
    repeat (3) @(negedge clk);
    checkOutput("hold done", done, 1);
    checkOutput("hold quotient", quotient, 6);

    // Started from DONE: 3969 / 63 = 63 r 0, then 35 / 6 = 5 r 5.
    runDivision("3969/63", 12'd3969, 6'd63, 6'd63, 6'd0);
    runDivision("35/6", 12'd35, 6'd6, 6'd5, 6'd5);

    // Load during the third RUN cycle is ignored; 35 / 6 result keeps latency.
    applyStimulus(12'd35, 6'd6);
    @(negedge clk);
    dividend = 12'd100;
    divisor  = 6'd7;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    checkOutput("ignored load busy", busy, 1);
    repeat (3) @(negedge clk);
    checkOutput("ignored load not done early", done, 0);
    @(negedge clk);
    checkOutput("ignored load done", done, 1);
    checkOutput("ignored load quotient", quotient, 5);
    checkOutput("ignored load remainder", remainder, 5);

`ifdef RSHIFT_DIV_ERR_EN
    // Divide by zero: DONE after one edge with the saturated error result.
    applyStimulus(12'd45, 6'd0);
    checkOutput("div0 done", done, 1);
    checkOutput("div0 busy", busy, 0);
    checkOutput("div0 err", err, 1);
    checkOutput("div0 quotient", quotient, 6'h3F);
    checkOutput("div0 remainder", remainder, 0);
    // 640 / 5: upper half 10 >= 5, quotient would overflow.
    applyStimulus(12'd640, 6'd5);
    checkOutput("ovf done", done, 1);
    checkOutput("ovf err", err, 1);
    checkOutput("ovf quotient", quotient, 6'h3F);
    checkOutput("ovf remainder", remainder, 0);
    runDivision("after err 30/5", 12'd30, 6'd5, 6'd6, 6'd0);
    checkOutput("after err err", err, 0);
`else
    // Divisor 0 runs the full iteration: all ones quotient, dividend low half.
    runDivision("45/0", 12'd45, 6'd0, 6'h3F, 6'd45);
`endif

    // Asynchronous reset mid-run clears everything without a clock edge.
    applyStimulus(12'd3969, 6'd63);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset done", done, 0);
    checkOutput("async reset quotient", quotient, 0);
    checkOutput("async reset remainder", remainder, 0);
    #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("no result after reset done", done, 0);
    checkOutput("no result after reset busy", busy, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rshift_div.md
RSHIFT_DIV -- requirements
Module: rshift_div

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: load  input  1  start request; samples dividend/divisor.
REQ-004 SHALL have port: dividend  input  12  unsigned dividend (e.g. a 6x6 product).
REQ-005 SHALL have port: divisor  input  6  unsigned divisor.
REQ-006 SHALL have port: quotient  output  6  registered unsigned quotient.
REQ-007 SHALL have port: remainder  output  6  registered unsigned remainder.
REQ-008 SHALL have port: busy  output  1  high while iterating.
REQ-009 SHALL have port: done  output  1  high while a result is held valid.
REQ-010 SHALL have port (only when RSHIFT_DIV_ERR_EN defined): err  output  1  divide-by-zero or quotient overflow.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-012 SHALL accept load only in IDLE or DONE; load=1 at rising edge captures operands, clears done, enters RUN.
REQ-013 SHALL ignore load while in RUN; operands and iteration unaffected.
REQ-014 SHALL use 13-bit working register P initialised to {1'b0, dividend} on accepted load.
REQ-015 SHALL per RUN cycle: shift P left 1; if P[12:6] >= {1'b0, divisor} then P[12:6] -= divisor and P[0] = 1.
REQ-016 SHALL run exactly 6 iterations using a 3-bit counter, then enter DONE.
REQ-017 SHALL give fixed latency: load accepted at edge N -> done=1 and results valid after edge N+6.
REQ-018 SHALL drive quotient=P[5:0], remainder=P[11:6] in DONE, held until next accepted load.
REQ-019 SHALL drive quotient and remainder to 0 in IDLE and RUN.
REQ-020 SHALL stay in DONE indefinitely absent load; DONE+load behaves as IDLE+load.
REQ-021 SHALL produce exact results whenever divisor != 0 and dividend[11:6] < divisor.

Reset
REQ-022 SHALL on reset=0 immediately (no clock) enter IDLE, clear P, counter, quotient, remainder, busy, done, err.
REQ-023 SHALL abandon any in-progress division on reset; no result is produced afterwards.
REQ-024 SHALL ignore load while reset=0; first load accepted at first rising edge with reset=1.

Configuration
REQ-025 SHALL, with RSHIFT_DIV_ERR_EN defined, check at load: divisor==0 or dividend[11:6] >= divisor -> skip RUN, enter DONE next edge, quotient=6'h3F, remainder=6'h00, err=1.
REQ-026 SHALL, with RSHIFT_DIV_ERR_EN defined, hold err=0 for valid operands and clear err on each accepted load.
REQ-027 SHALL, without RSHIFT_DIV_ERR_EN, omit err port and checks; all operands take 6-cycle RUN per REQ-015 (divisor 0 -> quotient 6'h3F, remainder dividend[5:0]).

Verification
REQ-028 SHALL cover: dividend 30, divisor 5, one-cycle load -> busy 6 cycles, then done=1, quotient 6, remainder 0.
REQ-029 SHALL cover: dividend 3969, divisor 63 -> quotient 63, remainder 0; dividend 35, divisor 6 -> quotient 5, remainder 5.
REQ-030 SHALL cover: load=1 again at 3rd RUN cycle with dividend 100, divisor 7 -> ignored, original result returned at original latency.
REQ-031 SHALL cover: reset=0 pulse between clock edges during RUN -> busy, done, quotient, remainder 0 immediately; no done follows.
REQ-032 SHALL cover (ERR_EN): divisor 0 -> done after 1 edge, err=1, quotient 6'h3F; dividend 640, divisor 5 -> same; next valid load clears err.
REQ-033 SHALL cover (no ERR_EN): dividend 45, divisor 0 -> after 6 cycles quotient 6'h3F, remainder 45.
